// File: rtl/cpu_defs_pkg.sv
// Shared CPU-side definitions: interrupt controller register offsets and default base address.
package cpu_defs;

    localparam logic [15:0] DEF_BASE_ADDR = 16'hFF00;

    localparam logic [2:0] REG_PEND   = 3'd0;
    localparam logic [2:0] REG_EN     = 3'd1;
    localparam logic [2:0] REG_MODE   = 3'd2;
    localparam logic [2:0] REG_POL    = 3'd3;
    localparam logic [2:0] REG_ID     = 3'd4;
    localparam logic [2:0] REG_SWTRIG = 3'd5;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        we;
    } bus_req_t;

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder; idx is 0 when nothing is requested.
module prio_enc #(
    parameter int N = 8
) (
    input  logic [N-1:0] req,
    output logic [3:0]   idx,
    output logic         valid
);

    always_comb begin
        idx = 4'd0;
        // Walk downward so the lowest set index is the last assignment.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = 4'(i);
        end
    end

    assign valid = |req;

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: synchronises sources, latches pending,
// masks and prioritises them, and raises the CPU interrupt request.
module irq_ctrl
    import cpu_defs::*;
#(
    parameter int          N_SRC     = 8,
    parameter logic [15:0] BASE_ADDR = DEF_BASE_ADDR
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ce,
    input  logic [15:0]      i_addr,
    input  logic [15:0]      i_wdata,
    input  logic             i_we,
    input  logic [N_SRC-1:0] i_irq,
    output logic [15:0]      o_rdata,
    output logic             o_sel,
    output logic             o_int
);

    bus_req_t         req;
    logic [N_SRC-1:0] sync1, sync2, prev;
    logic [N_SRC-1:0] pend_q, en_q, mode_q, pol_q;
    logic [N_SRC-1:0] pend_nxt, en_nxt, mode_nxt, pol_nxt;
    logic [N_SRC-1:0] active, edge_ev, w1c, swtrig, pending, pending_nxt, masked;
    logic [N_SRC-1:0] wfield;
    logic [15:0]      rd_mux;
    logic [3:0]       id_idx;
    logic             id_vld, hit, wr;
    logic [2:0]       off;
    logic             unused_wdata;

    assign req          = '{addr: i_addr, wdata: i_wdata, we: i_we};
    assign hit          = (req.addr[15:3] == BASE_ADDR[15:3]);
    assign off          = req.addr[2:0];
    assign wr           = req.we & hit;
    assign wfield       = req.wdata[N_SRC-1:0];
    assign unused_wdata = ^req.wdata[15:N_SRC];

    // Synchroniser runs every clock; everything downstream is i_ce-gated.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= i_irq;
            sync2 <= sync1;
        end
    end

    assign active  = sync2 ^ pol_q;
    assign edge_ev = active & ~prev;

    always_comb begin
        w1c      = '0;
        swtrig   = '0;
        en_nxt   = en_q;
        mode_nxt = mode_q;
        pol_nxt  = pol_q;
        if (wr) begin
            case (off)
                REG_PEND:   w1c      = wfield;
                REG_EN:     en_nxt   = wfield;
                REG_MODE:   mode_nxt = wfield;
                REG_POL:    pol_nxt  = wfield;
                REG_SWTRIG: swtrig   = wfield;
                default:    ;
            endcase
        end
        // Set terms OR in after the clear so a coincident event survives W1C.
        pend_nxt    = ((pend_q & ~w1c) | edge_ev | swtrig) & mode_nxt;
        pending     = (pend_q & mode_q) | (active & ~mode_q);
        pending_nxt = (pend_nxt & mode_nxt) | (active & ~mode_nxt);
    end

    assign masked = pending & en_q;

    prio_enc #(.N(N_SRC)) u_prio (
        .req   (masked),
        .idx   (id_idx),
        .valid (id_vld)
    );

    always_comb begin
        rd_mux = 16'h0000;
        case (off)
            REG_PEND: rd_mux = 16'(pending);
            REG_EN:   rd_mux = 16'(en_q);
            REG_MODE: rd_mux = 16'(mode_q);
            REG_POL:  rd_mux = 16'(pol_q);
            REG_ID:   rd_mux = {id_vld, 11'd0, id_idx};
            default:  rd_mux = 16'h0000;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prev    <= '0;
            pend_q  <= '0;
            en_q    <= '0;
            mode_q  <= '0;
            pol_q   <= '0;
            o_rdata <= 16'h0000;
            o_sel   <= 1'b0;
            o_int   <= 1'b0;
        end else if (i_ce) begin
            prev    <= active;
            pend_q  <= pend_nxt;
            en_q    <= en_nxt;
            mode_q  <= mode_nxt;
            pol_q   <= pol_nxt;
            o_int   <= |(pending_nxt & en_nxt);
            o_sel   <= hit;
            o_rdata <= hit ? rd_mux : 16'h0000;
        end
    end

endmodule
